// File: rtl/cpu_core_p.sv
// ============================================================================
//  Module   : cpu_core_p
//  Purpose  : Accumulator CPU core with a FETCH/EXEC/HALT controller, a small
//             register file and relative branches. Optional macro
//             CPU_CORE_SHIFT_EN adds the SHL/SHR opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_core_p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int REG_AW = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [ADDR_W-1:0]     imem_addr,
   input  logic                  imem_ack,
   input  logic [4+REG_AW-1:0]   imem_data,
   output logic [4+REG_AW-1:0]   ir,
   output logic [DATA_W-1:0]     acc,
   output logic [1:0]            flags,
   output logic                  retire,
   output logic                  halted
);

   localparam int c_IW = 4 + REG_AW;

   localparam logic [3:0] c_OP_LD  = 4'h1;
   localparam logic [3:0] c_OP_ST  = 4'h2;
   localparam logic [3:0] c_OP_ADD = 4'h3;
   localparam logic [3:0] c_OP_SUB = 4'h4;
   localparam logic [3:0] c_OP_AND = 4'h5;
   localparam logic [3:0] c_OP_OR  = 4'h6;
   localparam logic [3:0] c_OP_XOR = 4'h7;
   localparam logic [3:0] c_OP_LDI = 4'h8;
   localparam logic [3:0] c_OP_JMP = 4'h9;
`ifdef CPU_CORE_SHIFT_EN
   localparam logic [3:0] c_OP_SHL = 4'hA;
   localparam logic [3:0] c_OP_SHR = 4'hB;
`endif
   localparam logic [3:0] c_OP_JZ  = 4'hC;
   localparam logic [3:0] c_OP_JC  = 4'hD;
   localparam logic [3:0] c_OP_HLT = 4'hF;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      pc_q, pc_d;
   logic [c_IW-1:0]        ir_q, ir_d;
   logic [DATA_W-1:0]      acc_q, acc_d;
   logic                   c_q, c_d;
   logic                   z_q, z_d;
   logic [DATA_W-1:0]      rf_q [2**REG_AW];

   logic                   w_rf_we;
   logic                   w_upd_z;
   logic [3:0]             w_opc;
   logic [REG_AW-1:0]      w_n;
   logic [DATA_W-1:0]      w_rdata;
   logic [DATA_W:0]        w_sum;
   logic [DATA_W:0]        w_diff;
   logic [ADDR_W-1:0]      w_pc_rel;

   assign w_opc    = ir_q[c_IW-1:c_IW-4];
   assign w_n      = ir_q[REG_AW-1:0];
   assign w_rdata  = rf_q[w_n];
   assign w_sum    = {1'b0, acc_q} + {1'b0, w_rdata};
   // The extra top bit of the difference is the unsigned borrow.
   assign w_diff   = {1'b0, acc_q} - {1'b0, w_rdata};
   assign w_pc_rel = pc_q + ADDR_W'($signed(w_n));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      w_rf_we = 1'b0;
      w_upd_z = 1'b0;

      case (state_q)
         FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_data;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = EXEC;
            end
         end

         EXEC: begin
            state_d = FETCH;
            case (w_opc)
               c_OP_LD: begin
                  acc_d   = w_rdata;
                  w_upd_z = 1'b1;
               end
               c_OP_ST: begin
                  w_rf_we = 1'b1;
               end
               c_OP_ADD: begin
                  acc_d   = w_sum[DATA_W-1:0];
                  c_d     = w_sum[DATA_W];
                  w_upd_z = 1'b1;
               end
               c_OP_SUB: begin
                  acc_d   = w_diff[DATA_W-1:0];
                  c_d     = w_diff[DATA_W];
                  w_upd_z = 1'b1;
               end
               c_OP_AND: begin
                  acc_d   = acc_q & w_rdata;
                  w_upd_z = 1'b1;
               end
               c_OP_OR: begin
                  acc_d   = acc_q | w_rdata;
                  w_upd_z = 1'b1;
               end
               c_OP_XOR: begin
                  acc_d   = acc_q ^ w_rdata;
                  w_upd_z = 1'b1;
               end
               c_OP_LDI: begin
                  acc_d   = DATA_W'(w_n);
                  w_upd_z = 1'b1;
               end
               c_OP_JMP: begin
                  pc_d = w_pc_rel;
               end
`ifdef CPU_CORE_SHIFT_EN
               c_OP_SHL: begin
                  acc_d   = {acc_q[DATA_W-2:0], 1'b0};
                  c_d     = acc_q[DATA_W-1];
                  w_upd_z = 1'b1;
               end
               c_OP_SHR: begin
                  acc_d   = {1'b0, acc_q[DATA_W-1:1]};
                  c_d     = acc_q[0];
                  w_upd_z = 1'b1;
               end
`endif
               c_OP_JZ: begin
                  if (z_q) begin
                     pc_d = w_pc_rel;
                  end
               end
               c_OP_JC: begin
                  if (c_q) begin
                     pc_d = w_pc_rel;
                  end
               end
               c_OP_HLT: begin
                  state_d = HALT;
               end
               default: begin
               end
            endcase
            if (w_upd_z) begin
               z_d = (acc_d == '0);
            end
         end

         HALT: begin
            state_d = HALT;
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         for (int i = 0; i < 2**REG_AW; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         if (w_rf_we) begin
            rf_q[w_n] <= acc_q;
         end
      end
   end

   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign acc       = acc_q;
   assign flags     = {c_q, z_q};
   assign retire    = (state_q == EXEC);
   assign halted    = (state_q == HALT);

endmodule

`default_nettype wire
